// File: rtl/sha256_sched_ctrl.sv
// SHA-256 message-schedule round controller: block handshake, load/slide sequencing, done pulse.
// Optional SHA_CTRL_BLKCNT_EN adds blk_count, a wrapping count of done pulses.
module sha256_sched_ctrl #(
  parameter int unsigned ROUNDS = 64,
  parameter int unsigned TW     = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          blk_valid,
  output logic          blk_ready,
  input  logic [511:0]  blk_data,
  input  logic          blk_last,
  input  logic          stall,
  input  logic          abort,
  output logic [511:0]  sched_block,
  output logic          sched_init,
  output logic          sched_shift,
  output logic [TW-1:0] sched_t,
  output logic          round_en,
  output logic          busy,
  output logic          done,
`ifdef SHA_CTRL_BLKCNT_EN
  output logic [31:0]   blk_count,
`endif
  output logic          done_last
);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  localparam logic [TW-1:0] TLoadEnd = TW'(15);
  localparam logic [TW-1:0] TLast    = TW'(ROUNDS - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [511:0]  block_q;
  logic          last_q;
  logic          accept;

  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    sched_init  = 1'b0;
    sched_shift = 1'b0;
    round_en    = 1'b0;
    done        = 1'b0;
    done_last   = 1'b0;
    busy        = (state_q != StIdle);
    blk_ready   = (state_q == StIdle) && !rst;
    accept      = blk_valid && blk_ready;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StLoad;
          t_d     = '0;
        end
      end
      StLoad: begin
        // abort wins over stall and over the round that would otherwise advance
        if (abort) begin
          state_d = StIdle;
          t_d     = '0;
        end else if (!stall) begin
          sched_init = 1'b1;
          round_en   = 1'b1;
          t_d        = t_q + TW'(1);
          if (t_q == TLoadEnd) state_d = StShift;
        end
      end
      StShift: begin
        if (abort) begin
          state_d = StIdle;
          t_d     = '0;
        end else if (!stall) begin
          sched_shift = 1'b1;
          round_en    = 1'b1;
          // leaving SHIFT instead of incrementing keeps t_q from wrapping
          if (t_q == TLast) state_d = StDone;
          else              t_d     = t_q + TW'(1);
        end
      end
      StDone: begin
        done      = 1'b1;
        done_last = last_q;
        state_d   = StIdle;
        t_d       = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      t_q     <= '0;
      block_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      if (accept) begin
        block_q <= blk_data;
        last_q  <= blk_last;
      end
    end
  end

  assign sched_block = block_q;
  assign sched_t     = t_q;

`ifdef SHA_CTRL_BLKCNT_EN
  logic [31:0] cnt_q;
  logic        clr_q;

  // A final block clears the count one cycle after its done, so the count still shows it once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      clr_q <= 1'b0;
    end else begin
      clr_q <= done && done_last;
      if (clr_q)     cnt_q <= '0;
      else if (done) cnt_q <= cnt_q + 32'd1;
    end
  end

  assign blk_count = cnt_q;
`endif

endmodule

// File: tb/tb_sha256_sched_ctrl.sv
// Scoreboard bench for sha256_sched_ctrl: round indices and last flags queued at acceptance.
// Define SHA_CTRL_BLKCNT_EN to also exercise blk_count.
module tb_sha256_sched_ctrl;
  localparam int unsigned ROUNDS = 64;
  localparam int unsigned TW     = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          blk_valid, blk_ready, blk_last, stall, abort;
  logic [511:0]  blk_data, sched_block;
  logic          sched_init, sched_shift, round_en, busy, done, done_last;
  logic [TW-1:0] sched_t;
`ifdef SHA_CTRL_BLKCNT_EN
  logic [31:0]   blk_count;
`endif

  int tests = 0;
  int fails = 0;
  int exp_t[$];
  bit exp_last[$];

  sha256_sched_ctrl #(.ROUNDS(ROUNDS), .TW(TW)) dut (
    .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_last(blk_last), .stall(stall), .abort(abort), .sched_block(sched_block),
    .sched_init(sched_init), .sched_shift(sched_shift), .sched_t(sched_t),
    .round_en(round_en), .busy(busy), .done(done),
`ifdef SHA_CTRL_BLKCNT_EN
    .blk_count(blk_count),
`endif
    .done_last(done_last)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic push_block(input bit last);
    for (int i = 0; i < int'(ROUNDS); i++) exp_t.push_back(i);
    exp_last.push_back(last);
  endtask

  task automatic wait_done(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      cycle(); #1;
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; blk_valid = 1'b1; blk_data = {16{32'hdeadbeef}}; blk_last = 1'b1;
    stall = 1'b0; abort = 1'b0;
    repeat (3) cycle();
    #1;
    tests++;
    if ({blk_ready, sched_init, sched_shift, round_en, busy, done, done_last} !== 7'b0 ||
        sched_t !== '0 || sched_block !== '0) begin
      fails++;
      $display("FAIL reset_outputs: ready=%b init=%b shift=%b ren=%b busy=%b done=%b dl=%b t=%0d blk0=%b, required all 0",
               blk_ready, sched_init, sched_shift, round_en, busy, done, done_last, sched_t,
               sched_block == '0);
    end
    cycle(); rst = 1'b0; blk_valid = 1'b0; #1;
    tests++;
    if (blk_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: ready=%b busy=%b, required 1 0", blk_ready, busy);
    end
  endtask

  task automatic test_single();
    logic [511:0] d;
    logic ei, es;
    int e;
    d = {16{32'h01234567}} ^ 512'h5a;
    cycle(); blk_valid = 1'b1; blk_data = d; blk_last = 1'b1; #1;
    tests++;
    if (blk_ready !== 1'b1) begin
      fails++; $display("FAIL single_ready0: ready=%b required 1", blk_ready);
    end
    push_block(1'b1);
    for (int c = 1; c <= 66; c++) begin
      cycle(); blk_valid = 1'b0; #1;
      if (c <= 64) begin
        ei = (c <= 16);
        es = (c >= 17);
        tests++;
        if (sched_init !== ei || sched_shift !== es || round_en !== 1'b1 || sched_block !== d) begin
          fails++;
          $display("FAIL single_ctl c=%0d: init=%b shift=%b ren=%b blk_ok=%b, required %b %b 1 1",
                   c, sched_init, sched_shift, round_en, sched_block == d, ei, es);
        end
        tests++;
        if (exp_t.size() == 0) begin
          fails++; $display("FAIL single_t c=%0d: scoreboard empty, t=%0d", c, sched_t);
        end else begin
          e = exp_t.pop_front();
          if (sched_t !== TW'(e)) begin
            fails++; $display("FAIL single_t c=%0d: t=%0d required %0d", c, sched_t, e);
          end
        end
      end else if (c == 65) begin
        tests++;
        if (done !== 1'b1 || done_last !== exp_last[0] || busy !== 1'b1 || round_en !== 1'b0) begin
          fails++;
          $display("FAIL single_done: done=%b dl=%b busy=%b ren=%b, required 1 %b 1 0",
                   done, done_last, busy, round_en, exp_last[0]);
        end
        void'(exp_last.pop_front());
      end else begin
        tests++;
        if (blk_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
          fails++;
          $display("FAIL single_ready66: ready=%b done=%b busy=%b, required 1 0 0",
                   blk_ready, done, busy);
        end
      end
    end
  endtask

  task automatic test_stall();
    int ren, done_c, e;
    ren = 0; done_c = -1;
    cycle(); blk_valid = 1'b1; blk_data = {16{32'h89abcdef}}; blk_last = 1'b0; #1;
    push_block(1'b0);
    for (int c = 1; c <= 72; c++) begin
      // cycle 19 is t=15, the last LOAD round; cycle 69 stalls the DONE cycle
      cycle(); blk_valid = 1'b0; stall = ((c >= 5 && c <= 7) || c == 19 || c == 69); #1;
      if (round_en === 1'b1) ren++;
      if (done === 1'b1 && done_c < 0) begin
        done_c = c;
        tests++;
        if (done_last !== exp_last[0]) begin
          fails++; $display("FAIL stall_done_last: dl=%b required %b", done_last, exp_last[0]);
        end
        void'(exp_last.pop_front());
      end
      if (c <= 68) begin
        tests++;
        if (exp_t.size() == 0) begin
          fails++; $display("FAIL stall_sb c=%0d: scoreboard empty", c);
        end else if (stall) begin
          if (round_en !== 1'b0 || sched_init !== 1'b0 || sched_shift !== 1'b0 ||
              sched_t !== TW'(exp_t[0])) begin
            fails++;
            $display("FAIL stall_hold c=%0d: ren=%b init=%b shift=%b t=%0d, required 0 0 0 t=%0d",
                     c, round_en, sched_init, sched_shift, sched_t, exp_t[0]);
          end
        end else begin
          e = exp_t.pop_front();
          if (round_en !== 1'b1 || sched_t !== TW'(e)) begin
            fails++;
            $display("FAIL stall_round c=%0d: ren=%b t=%0d, required 1 t=%0d", c, round_en, sched_t, e);
          end
        end
      end else if (c == 70) begin
        tests++;
        if (blk_ready !== 1'b1) begin
          fails++; $display("FAIL stall_ready70: ready=%b required 1", blk_ready);
        end
      end
    end
    stall = 1'b0;
    tests++;
    if (done_c != 69) begin
      fails++; $display("FAIL stall_done_cycle: done at %0d required 69", done_c);
    end
    tests++;
    if (ren != int'(ROUNDS)) begin
      fails++; $display("FAIL stall_round_count: %0d round_en pulses required %0d", ren, ROUNDS);
    end
  endtask

  task automatic test_abort();
    logic [511:0] d2;
    int e;
    bit got_done;
    d2 = {16{32'hcafef00d}};
    got_done = 1'b0;
    cycle(); blk_valid = 1'b1; blk_data = {16{32'h11111111}}; blk_last = 1'b1; #1;
    push_block(1'b1);
    for (int c = 1; c <= 31; c++) begin
      // abort lands together with a stall at t=30
      cycle(); blk_valid = 1'b0; abort = (c == 31); stall = (c == 31); #1;
      e = exp_t.pop_front();
      if (c == 31) begin
        tests++;
        if (sched_t !== TW'(e)) begin
          fails++; $display("FAIL abort_t30: t=%0d required %0d", sched_t, e);
        end
      end
    end
    exp_t.delete(); exp_last.delete();
    cycle(); abort = 1'b0; stall = 1'b0;
    blk_valid = 1'b1; blk_data = d2; blk_last = 1'b0; #1;
    tests++;
    if (busy !== 1'b0 || blk_ready !== 1'b1 || sched_t !== '0 || done !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: busy=%b ready=%b t=%0d done=%b, required 0 1 0 0",
               busy, blk_ready, sched_t, done);
    end
    push_block(1'b0);
    for (int c = 33; c <= 110; c++) begin
      cycle(); blk_valid = 1'b0; #1;
      if (c == 33) begin
        tests++;
        if (sched_init !== 1'b1 || sched_block !== d2) begin
          fails++;
          $display("FAIL abort_restart: init=%b blk_ok=%b, required 1 1", sched_init, sched_block == d2);
        end
      end
      if (round_en === 1'b1 && exp_t.size() != 0) begin
        e = exp_t.pop_front();
        if (sched_t !== TW'(e)) begin
          tests++; fails++;
          $display("FAIL abort_round c=%0d: t=%0d required %0d", c, sched_t, e);
        end
      end
      if (done === 1'b1) begin
        got_done = 1'b1;
        tests++;
        if (c != 97 || done_last !== exp_last[0] || exp_t.size() != 0) begin
          fails++;
          $display("FAIL abort_second_done: at %0d dl=%b left=%0d, required 97 %b 0",
                   c, done_last, exp_t.size(), exp_last[0]);
        end
        exp_last.delete();
        break;
      end
    end
    tests++;
    if (!got_done) begin
      fails++; $display("FAIL abort_second_timeout: no done seen, required done at 97");
    end
  endtask

  task automatic test_rst_mid();
    cycle(); blk_valid = 1'b1; blk_data = {16{32'h22222222}}; blk_last = 1'b1; #1;
    for (int c = 1; c <= 41; c++) begin
      cycle(); blk_valid = 1'b0; #1;
    end
    tests++;
    if (sched_t !== TW'(40) || busy !== 1'b1) begin
      fails++; $display("FAIL rst_mid_pre: t=%0d busy=%b, required 40 1", sched_t, busy);
    end
    #1 rst = 1'b1;
    #1;
    tests++;
    if ({blk_ready, sched_init, sched_shift, round_en, busy, done, done_last} !== 7'b0 ||
        sched_t !== '0 || sched_block !== '0) begin
      fails++;
      $display("FAIL rst_mid_async: ready=%b init=%b shift=%b ren=%b busy=%b done=%b dl=%b t=%0d, required all 0",
               blk_ready, sched_init, sched_shift, round_en, busy, done, done_last, sched_t);
    end
    cycle(); rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cycle(); #1;
      tests++;
      if (blk_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL rst_mid_after c=%0d: ready=%b done=%b busy=%b, required 1 0 0",
                 c, blk_ready, done, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [511:0] d1, d2;
    int n;
    d1 = {16{32'h33333333}};
    d2 = {16{32'h44444444}};
    cycle(); blk_valid = 1'b1; blk_data = d1; blk_last = 1'b0; #1;
    tests++;
    if (blk_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_ready0: ready=%b required 1", blk_ready);
    end
    for (int c = 1; c <= 66; c++) begin
      cycle(); blk_data = d2; #1;
      if (c <= 65) begin
        tests++;
        if (sched_block !== d1 || blk_ready !== 1'b0) begin
          fails++;
          $display("FAIL b2b_hold c=%0d: blk_ok=%b ready=%b, required 1 0", c, sched_block == d1, blk_ready);
        end
      end
      if (c == 65) begin
        tests++;
        if (done !== 1'b1) begin
          fails++; $display("FAIL b2b_done1: done=%b required 1", done);
        end
      end
      if (c == 66) begin
        tests++;
        if (blk_ready !== 1'b1) begin
          fails++; $display("FAIL b2b_accept66: ready=%b required 1", blk_ready);
        end
      end
    end
    cycle(); blk_valid = 1'b0; #1;
    tests++;
    if (sched_block !== d2 || sched_init !== 1'b1 || sched_t !== '0) begin
      fails++;
      $display("FAIL b2b_second: blk_ok=%b init=%b t=%0d, required 1 1 0",
               sched_block == d2, sched_init, sched_t);
    end
    wait_done(80, n);
    tests++;
    if (n != 64) begin
      fails++; $display("FAIL b2b_done2: done after %0d more cycles, required 64", n);
    end
  endtask

`ifdef SHA_CTRL_BLKCNT_EN
  task automatic test_blkcnt();
    int exp_cnt[$];
    int n, e;
    cycle(); rst = 1'b1;
    cycle(); rst = 1'b0; #1;
    tests++;
    if (blk_count !== 32'd0) begin
      fails++; $display("FAIL cnt_reset: count=%0d required 0", blk_count);
    end
    for (int b = 0; b < 3; b++) begin
      cycle(); blk_valid = 1'b1; blk_last = (b == 2); blk_data = {16{32'(b + 5)}}; #1;
      exp_cnt.push_back(b + 1);
      cycle(); blk_valid = 1'b0;
      wait_done(80, n);
      tests++;
      if (n < 0) begin
        fails++; $display("FAIL cnt_done%0d: no done, required one", b);
      end
      cycle(); #1;
      e = exp_cnt.pop_front();
      tests++;
      if (blk_count !== 32'(e)) begin
        fails++; $display("FAIL cnt_value%0d: count=%0d required %0d", b, blk_count, e);
      end
    end
    cycle(); #1;
    tests++;
    if (blk_count !== 32'd0) begin
      fails++; $display("FAIL cnt_clear: count=%0d required 0", blk_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_abort();
    test_rst_mid();
    test_back_to_back();
`ifdef SHA_CTRL_BLKCNT_EN
    test_blkcnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
